// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a shared ALU: round-robin grant, one op in flight,
// registered operands to the ALU and a held response to the winning requester.
module alu_share_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_ctrl,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp_w,
   output logic             resp_zero,
   output logic             resp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_w,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [3:0]       op_ctrl_q, op_ctrl_d;
   logic [WIDTH-1:0] res_w_q, res_w_d;
   logic             res_zero_q, res_zero_d;
   logic             res_err_q, res_err_d;
   logic [1:0]       resp_valid_q, resp_valid_d;

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       resp_ready_in;
   logic             grant;
   logic             ctrl_legal;

   assign req_valid     = {req1_valid, req0_valid};
   assign resp_ready_in = {resp1_ready, resp0_ready};

   // A tie goes to whoever did not win last; a sole requester always wins.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b11) begin
         grant = ~last_grant_q;
      end else if (req_valid[1]) begin
         grant = 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign req_ready[gi] = !Reset && (state_q == ST_IDLE) && req_valid[gi]
                                && (grant == ((gi == 1) ? 1'b1 : 1'b0));
      end
   endgenerate

   always_comb begin
      case (op_ctrl_q)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: ctrl_legal = 1'b1;
         default:                                     ctrl_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_ctrl_d    = op_ctrl_q;
      res_w_d      = res_w_q;
      res_zero_d   = res_zero_q;
      res_err_d    = res_err_q;
      resp_valid_d = resp_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid != 2'b00) begin
               state_d      = ST_EXEC;
               owner_d      = grant;
               last_grant_d = grant;
               op_a_d       = grant ? req1_a : req0_a;
               op_b_d       = grant ? req1_b : req0_b;
               op_ctrl_d    = grant ? req1_ctrl : req0_ctrl;
            end
         end
         ST_EXEC: begin
            state_d      = ST_RESP;
            resp_valid_d = owner_q ? 2'b10 : 2'b01;
            // Illegal codes still spend the EXEC cycle, but the ALU output is discarded.
            if (ctrl_legal) begin
               res_w_d    = alu_w;
               res_zero_d = alu_zero;
               res_err_d  = 1'b0;
            end else begin
               res_w_d    = '0;
               res_zero_d = 1'b0;
               res_err_d  = 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_ready_in[owner_q]) begin
               state_d      = ST_IDLE;
               resp_valid_d = 2'b00;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            resp_valid_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_ctrl_q    <= '0;
         res_w_q      <= '0;
         res_zero_q   <= 1'b0;
         res_err_q    <= 1'b0;
         resp_valid_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_ctrl_q    <= op_ctrl_d;
         res_w_q      <= res_w_d;
         res_zero_q   <= res_zero_d;
         res_err_q    <= res_err_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign req0_ready  = req_ready[0];
   assign req1_ready  = req_ready[1];
   assign resp0_valid = resp_valid_q[0];
   assign resp1_valid = resp_valid_q[1];
   assign resp_w      = res_w_q;
   assign resp_zero   = res_zero_q;
   assign resp_err    = res_err_q;
   assign alu_a       = op_a_q;
   assign alu_b       = op_b_q;
   assign alu_ctrl    = op_ctrl_q;

endmodule
